// File: rtl/la_pkg.sv
// Shared types for the logic-analyser capture path.
//   la_cap_state_t : capture controller state encoding
//   state_busy()   : true while a capture is in progress (PRE, ARMED, POST)
package la_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StPre   = 3'd1,
        StArmed = 3'd2,
        StPost  = 3'd3,
        StDone  = 3'd4
    } la_cap_state_t;

    function automatic logic state_busy(la_cap_state_t s);
        return (s == StPre) || (s == StArmed) || (s == StPost);
    endfunction

endpackage

// File: rtl/la_trig_match.sv
// Combinational mask/value trigger comparator with optional edge qualifier.
// Build option: LA_TRIG_EDGE_EN adds the edge term (participating edge bits must
// differ from the previous sample); without it prev and trig_edge are ignored.
// Ports:
//   probe      : current probe sample
//   prev       : previous sample (edge build only)
//   trig_mask  : 1 = bit participates
//   trig_value : required level of participating bits
//   trig_edge  : 1 = participating bit must also have toggled
//   hit        : trigger condition true for this sample
module la_trig_match #(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] probe,
    input  logic [DATA_WIDTH-1:0] prev,
    input  logic [DATA_WIDTH-1:0] trig_mask,
    input  logic [DATA_WIDTH-1:0] trig_value,
    input  logic [DATA_WIDTH-1:0] trig_edge,
    output logic                  hit
);

    logic level_hit;
    assign level_hit = &(~trig_mask | ~(probe ^ trig_value));

`ifdef LA_TRIG_EDGE_EN
    logic edge_hit;
    assign edge_hit = &(~(trig_mask & trig_edge) | (probe ^ prev));
    assign hit      = level_hit & edge_hit;
`else
    logic unused_edge;
    assign unused_edge = ^{prev, trig_edge};
    assign hit         = level_hit;
`endif

endmodule

// File: rtl/la_capture_ctrl.sv
// Capture controller: sole writer of the sample FIFO during a capture. Keeps a
// sliding pre-trigger window (write + discard per sample), then stores the
// post-trigger samples, hiding the pre-window from the reader via fifo_level.
// Build option: LA_TRIG_EDGE_EN enables the edge trigger term and the
// previous-sample register.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   arm, abort              : start a capture / return to idle (abort wins)
//   sample_en, probe        : sample strobe and probe bus
//   trig_mask/value/edge    : trigger configuration
//   pre_depth, post_depth   : samples kept before / from the trigger onward
//   fifo_full               : FIFO full flag
//   fifo_wen/ren/din        : registered FIFO write, discard-read and data
//   fifo_level              : occupancy hidden from the reader
//   busy, triggered, done   : status
//   overflow                : a post sample was dropped on a full FIFO
module la_capture_ctrl
    import la_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  sample_en,
    input  logic [DATA_WIDTH-1:0] probe,
    input  logic [DATA_WIDTH-1:0] trig_mask,
    input  logic [DATA_WIDTH-1:0] trig_value,
    input  logic [DATA_WIDTH-1:0] trig_edge,
    input  logic [ADDR_WIDTH-1:0] pre_depth,
    input  logic [ADDR_WIDTH:0]   post_depth,
    input  logic                  fifo_full,
    output logic                  fifo_wen,
    output logic                  fifo_ren,
    output logic [DATA_WIDTH-1:0] fifo_din,
    output logic [ADDR_WIDTH-1:0] fifo_level,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done,
    output logic                  overflow
);

    localparam logic [ADDR_WIDTH:0] CntOne = {{ADDR_WIDTH{1'b0}}, 1'b1};

    la_cap_state_t         state;
    logic [ADDR_WIDTH:0]   cnt;
    logic [ADDR_WIDTH:0]   cnt_inc;
    logic [ADDR_WIDTH-1:0] pre_q;
    logic [ADDR_WIDTH:0]   post_q;
    logic [ADDR_WIDTH:0]   post_cnt;
    logic [ADDR_WIDTH:0]   post_load;
    logic [DATA_WIDTH-1:0] prev;
    logic                  hit;

`ifdef LA_TRIG_EDGE_EN
    // Tracks every strobed sample, even outside a capture, so the first ARMED
    // sample has a valid edge reference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= '0;
        end else if (sample_en) begin
            prev <= probe;
        end
    end
`else
    assign prev = '0;
`endif

    la_trig_match #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_trig_match (
        .probe      (probe),
        .prev       (prev),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .trig_edge  (trig_edge),
        .hit        (hit)
    );

    assign cnt_inc = cnt + CntOne;
    // The trigger sample itself counts toward post_depth, so a depth of 0 or 1
    // both mean "store only the trigger sample".
    assign post_load = (post_q == '0) ? '0 : post_q - CntOne;
    assign busy      = state_busy(state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            cnt        <= '0;
            pre_q      <= '0;
            post_q     <= '0;
            post_cnt   <= '0;
            fifo_wen   <= 1'b0;
            fifo_ren   <= 1'b0;
            fifo_din   <= '0;
            fifo_level <= '0;
            triggered  <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            fifo_wen   <= 1'b0;
            fifo_ren   <= 1'b0;
            // Follows the state register, so it lags a state change by one cycle.
            fifo_level <= (state == StPre || state == StArmed) ? pre_q : '0;

            if (abort) begin
                state <= StIdle;
                done  <= 1'b0;
            end else begin
                unique case (state)
                    StIdle, StDone: begin
                        if (arm) begin
                            pre_q     <= pre_depth;
                            post_q    <= post_depth;
                            cnt       <= '0;
                            triggered <= 1'b0;
                            done      <= 1'b0;
                            overflow  <= 1'b0;
                            state     <= (pre_depth == '0) ? StArmed : StPre;
                        end
                    end

                    StPre: begin
                        if (sample_en) begin
                            fifo_wen <= 1'b1;
                            fifo_din <= probe;
                            cnt      <= cnt_inc;
                            if (cnt_inc == {1'b0, pre_q}) begin
                                state <= StArmed;
                            end
                        end
                    end

                    StArmed: begin
                        if (sample_en) begin
                            if (hit) begin
                                fifo_wen  <= 1'b1;
                                fifo_din  <= probe;
                                cnt       <= cnt_inc;
                                triggered <= 1'b1;
                                post_cnt  <= post_load;
                                if (post_load == '0) begin
                                    state <= StDone;
                                    done  <= 1'b1;
                                end else begin
                                    state <= StPost;
                                end
                            end else if (pre_q != '0) begin
                                // Slide the window: oldest sample out, new one in.
                                fifo_wen <= 1'b1;
                                fifo_ren <= 1'b1;
                                fifo_din <= probe;
                            end
                        end
                    end

                    StPost: begin
                        if (sample_en) begin
                            if (fifo_full) begin
                                overflow <= 1'b1;
                            end else begin
                                fifo_wen <= 1'b1;
                                fifo_din <= probe;
                                cnt      <= cnt_inc;
                            end
                            post_cnt <= post_cnt - CntOne;
                            if (post_cnt == CntOne) begin
                                state <= StDone;
                                done  <= 1'b1;
                            end
                        end
                    end

                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule
